// File: rtl/usb_fs_in_pe_if.sv
// usb_fs_in_pe_if -- bundle of all non-clock/reset signals of the USB full-speed
// IN protocol engine.
//   Endpoint side : reset_ep, in_ep_data_put, in_ep_data, in_ep_data_done,
//                   in_ep_stall (to PE); in_ep_data_free, in_ep_acked (from PE)
//   Receiver side : rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp (to PE)
//   Transmitter   : tx_pkt_end, tx_data_get (to PE); tx_pkt_start, tx_pid,
//                   tx_data_avail, tx_data (from PE)
//   Misc          : dev_addr, bit_strobe (to PE)
// The PE uses the slave modport; whatever drives it uses the master modport.
interface usb_fs_in_pe_if #(
  parameter int NUM_IN_EPS = 1
);
  logic [NUM_IN_EPS-1:0] reset_ep;
  logic [6:0]            dev_addr;
  logic                  bit_strobe;
  logic [NUM_IN_EPS-1:0] in_ep_data_free;
  logic [NUM_IN_EPS-1:0] in_ep_data_put;
  logic [7:0]            in_ep_data;
  logic [NUM_IN_EPS-1:0] in_ep_data_done;
  logic [NUM_IN_EPS-1:0] in_ep_stall;
  logic [NUM_IN_EPS-1:0] in_ep_acked;
  logic                  rx_pkt_end;
  logic                  rx_pkt_valid;
  logic [3:0]            rx_pid;
  logic [6:0]            rx_addr;
  logic [3:0]            rx_endp;
  logic                  tx_pkt_start;
  logic                  tx_pkt_end;
  logic [3:0]            tx_pid;
  logic                  tx_data_avail;
  logic                  tx_data_get;
  logic [7:0]            tx_data;

  modport slave (
    input  reset_ep, dev_addr, bit_strobe, in_ep_data_put, in_ep_data,
           in_ep_data_done, in_ep_stall, rx_pkt_end, rx_pkt_valid, rx_pid,
           rx_addr, rx_endp, tx_pkt_end, tx_data_get,
    output in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid,
           tx_data_avail, tx_data
  );

  modport master (
    output reset_ep, dev_addr, bit_strobe, in_ep_data_put, in_ep_data,
           in_ep_data_done, in_ep_stall, rx_pkt_end, rx_pkt_valid, rx_pid,
           rx_addr, rx_endp, tx_pkt_end, tx_data_get,
    input  in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid,
           tx_data_avail, tx_data
  );
endinterface

// File: rtl/usb_fs_in_pe.sv
// usb_fs_in_pe -- USB full-speed IN-endpoint protocol engine.
// Buffers one packet per IN endpoint, answers IN tokens with DATA0/DATA1,
// NAK or STALL, streams the payload to the transmitter and waits for the
// host ACK (with a 20 bit-time timeout) before releasing the buffer.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-low
//   bus   - usb_fs_in_pe_if.slave (endpoint, receiver, transmitter signals)
module usb_fs_in_pe #(
  parameter int NUM_IN_EPS         = 1,
  parameter int MAX_IN_PACKET_SIZE = 32
) (
  input logic           clk,
  input logic           reset,
  usb_fs_in_pe_if.slave bus
);
  localparam int AW = $clog2(MAX_IN_PACKET_SIZE + 1);
  localparam int BW = (MAX_IN_PACKET_SIZE > 1) ? $clog2(MAX_IN_PACKET_SIZE) : 1;
  localparam int EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam logic [AW-1:0] MAX_ADDR = AW'(MAX_IN_PACKET_SIZE);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {EP_FILLING, EP_READY, EP_STALL} ep_state_t;
  typedef enum logic [1:0] {S_IDLE, S_RCVD_IN, S_SEND_DATA, S_WAIT_ACK} xfer_state_t;

  // Per-endpoint state
  ep_state_t       r_ep_state [NUM_IN_EPS];
  logic [AW-1:0]   r_put_addr [NUM_IN_EPS];
  logic            r_toggle   [NUM_IN_EPS];
  logic [7:0]      r_buf      [NUM_IN_EPS][MAX_IN_PACKET_SIZE];

  // Transfer state
  xfer_state_t     r_state;
  logic [EW-1:0]   r_cur_ep;
  logic [AW-1:0]   r_get_addr;
  logic [4:0]      r_timeout;
  logic [3:0]      r_tx_pid;
  logic [NUM_IN_EPS-1:0] r_acked;

  logic                  w_tok_ok;
  logic                  w_in_tok;
  logic                  w_setup_tok;
  logic                  w_ack;
  logic                  w_avail;
  logic                  w_send;
  logic [3:0]            w_pid_sel;
  logic [NUM_IN_EPS-1:0] w_put_ok;
  logic [NUM_IN_EPS-1:0] w_ack_ep;
  logic [NUM_IN_EPS-1:0] w_setup_ep;

  assign w_tok_ok    = bus.rx_pkt_end && bus.rx_pkt_valid &&
                       (bus.rx_addr == bus.dev_addr) &&
                       (32'(bus.rx_endp) < NUM_IN_EPS);
  assign w_in_tok    = w_tok_ok && (bus.rx_pid == PID_IN);
  assign w_setup_tok = w_tok_ok && (bus.rx_pid == PID_SETUP);
  assign w_ack       = (r_state == S_WAIT_ACK) && bus.rx_pkt_end &&
                       bus.rx_pkt_valid && (bus.rx_pid == PID_ACK);

  // Response selection for the endpoint addressed by the current IN token.
  always_comb begin
    w_pid_sel = PID_NAK;
    w_send    = 1'b0;
    if (r_ep_state[r_cur_ep] == EP_STALL) begin
      w_pid_sel = PID_STALL;
    end else if (r_ep_state[r_cur_ep] == EP_READY) begin
      w_pid_sel = r_toggle[r_cur_ep] ? PID_DATA1 : PID_DATA0;
      w_send    = 1'b1;
    end
  end

  assign w_avail           = (r_state == S_SEND_DATA) && (r_get_addr < r_put_addr[r_cur_ep]);
  assign bus.tx_data_avail = w_avail;
  assign bus.tx_data       = w_avail ? r_buf[r_cur_ep][r_get_addr[BW-1:0]] : 8'h00;
  assign bus.tx_pkt_start  = (r_state == S_RCVD_IN);
  // The pid is live during RCVD_IN and held afterwards for the transmitter.
  assign bus.tx_pid        = (r_state == S_RCVD_IN) ? w_pid_sel : r_tx_pid;
  assign bus.in_ep_acked   = r_acked;

  generate
    for (genvar gi = 0; gi < NUM_IN_EPS; gi++) begin : g_ep
      // Puts beyond the buffer end are dropped so put_addr saturates at MAX.
      assign w_put_ok[gi]   = bus.in_ep_data_put[gi] && (r_ep_state[gi] == EP_FILLING) &&
                              (r_put_addr[gi] != MAX_ADDR) && !bus.reset_ep[gi];
      assign w_ack_ep[gi]   = w_ack && (r_cur_ep == EW'(gi)) && (r_ep_state[gi] == EP_READY);
      assign w_setup_ep[gi] = w_setup_tok && (bus.rx_endp == 4'(gi));
      assign bus.in_ep_data_free[gi] = (r_ep_state[gi] == EP_FILLING);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ep_state[gi] <= EP_FILLING;
          r_put_addr[gi] <= '0;
          r_toggle[gi]   <= 1'b0;
        end else begin
          if (bus.reset_ep[gi]) begin
            r_put_addr[gi] <= '0;
            r_toggle[gi]   <= 1'b0;
          end else if (w_setup_ep[gi]) begin
            r_put_addr[gi] <= '0;
            r_toggle[gi]   <= 1'b1;
          end else if (w_ack_ep[gi]) begin
            r_put_addr[gi] <= '0;
            r_toggle[gi]   <= ~r_toggle[gi];
          end else if (w_put_ok[gi]) begin
            r_put_addr[gi] <= r_put_addr[gi] + 1'b1;
          end

          // Stall overrides every other state change; it is sticky until SETUP.
          if (bus.in_ep_stall[gi]) begin
            r_ep_state[gi] <= EP_STALL;
          end else if (bus.reset_ep[gi] || w_setup_ep[gi]) begin
            r_ep_state[gi] <= EP_FILLING;
          end else if ((r_ep_state[gi] == EP_FILLING) && bus.in_ep_data_done[gi]) begin
            r_ep_state[gi] <= EP_READY;
          end else if (w_ack_ep[gi]) begin
            r_ep_state[gi] <= EP_FILLING;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_put_ok[gi]) begin
          r_buf[gi][r_put_addr[gi][BW-1:0]] <= bus.in_ep_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cur_ep   <= '0;
      r_get_addr <= '0;
      r_timeout  <= '0;
      r_tx_pid   <= '0;
      r_acked    <= '0;
    end else begin
      r_acked <= w_ack_ep;
      case (r_state)
        S_IDLE: begin
          if (w_in_tok) begin
            r_cur_ep   <= bus.rx_endp[EW-1:0];
            r_get_addr <= '0;
            r_state    <= S_RCVD_IN;
          end
        end
        S_RCVD_IN: begin
          r_tx_pid <= w_pid_sel;
          r_state  <= w_send ? S_SEND_DATA : S_IDLE;
        end
        S_SEND_DATA: begin
          if (w_avail && bus.tx_data_get) begin
            r_get_addr <= r_get_addr + 1'b1;
          end
          if (bus.tx_pkt_end) begin
            r_timeout <= '0;
            r_state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // Any received packet ends the wait; only an ACK (handled in the
          // endpoint logic) releases the buffer.
          if (bus.rx_pkt_end) begin
            r_state <= S_IDLE;
          end else if (bus.bit_strobe) begin
            if (r_timeout == 5'd19) begin
              r_state <= S_IDLE;
            end else begin
              r_timeout <= r_timeout + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_fs_in_pe.sv
// Directed testbench for usb_fs_in_pe (two IN endpoints, 32-byte buffers).
module tb_usb_fs_in_pe;
  localparam int NEP = 2;
  localparam logic [6:0] DEV = 7'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];

  usb_fs_in_pe_if #(.NUM_IN_EPS(NEP)) bus ();

  usb_fs_in_pe #(.NUM_IN_EPS(NEP), .MAX_IN_PACKET_SIZE(32)) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reset_ep = '0; bus.dev_addr = DEV; bus.bit_strobe = 1'b0;
    bus.in_ep_data_put = '0; bus.in_ep_data = 8'h00; bus.in_ep_data_done = '0;
    bus.in_ep_stall = '0; bus.rx_pkt_end = 1'b0; bus.rx_pkt_valid = 1'b0;
    bus.rx_pid = 4'h0; bus.rx_addr = 7'h00; bus.rx_endp = 4'h0;
    bus.tx_pkt_end = 1'b0; bus.tx_data_get = 1'b0;
  endtask

  task automatic put_byte(input int ep, input logic [7:0] b);
    bus.in_ep_data_put[ep] = 1'b1; bus.in_ep_data = b;
    tick();
    bus.in_ep_data_put = '0;
  endtask

  task automatic commit(input int ep);
    bus.in_ep_data_done[ep] = 1'b1;
    tick();
    bus.in_ep_data_done = '0;
  endtask

  task automatic token(input logic [3:0] pid, input logic [6:0] addr,
                       input logic [3:0] endp, input logic valid);
    bus.rx_pkt_end = 1'b1; bus.rx_pkt_valid = valid;
    bus.rx_pid = pid; bus.rx_addr = addr; bus.rx_endp = endp;
    tick();
    bus.rx_pkt_end = 1'b0; bus.rx_pkt_valid = 1'b0;
    $display("  RX pid=%b addr=%h ep=%0d valid=%b -> start=%b tx_pid=%b",
             pid, addr, endp, valid, bus.tx_pkt_start, bus.tx_pid);
  endtask

  // Drains the payload (bounded) then signals end of the transmitted packet.
  task automatic collect();
    got.delete();
    for (int i = 0; i < 64; i++) begin
      if (!bus.tx_data_avail) break;
      got.push_back(bus.tx_data);
      bus.tx_data_get = 1'b1;
      tick();
      bus.tx_data_get = 1'b0;
    end
    bus.tx_pkt_end = 1'b1;
    tick();
    bus.tx_pkt_end = 1'b0;
    $display("  TX payload %0d bytes", got.size());
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.bit_strobe = 1'b1; tick(); bus.bit_strobe = 1'b0; tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.tx_pkt_start, bus.tx_pid, bus.tx_data_avail, bus.tx_data, bus.in_ep_acked, bus.in_ep_data_free}
        !== {1'b0, 4'h0, 1'b0, 8'h00, 2'b00, 2'b11}) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b",
        {bus.tx_pkt_start, bus.tx_pid, bus.tx_data_avail, bus.tx_data, bus.in_ep_acked, bus.in_ep_data_free},
        {1'b0, 4'h0, 1'b0, 8'h00, 2'b00, 2'b11});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ep_data_free !== 2'b11 || bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL reset_release got free=%b start=%b exp free=11 start=0",
                         bus.in_ep_data_free, bus.tx_pkt_start);
    end
  endtask

  task automatic test_basic();
    put_byte(0, 8'h11); put_byte(0, 8'h22); put_byte(0, 8'h33);
    commit(0);
    checks++;
    if (bus.in_ep_data_free !== 2'b10) begin
      errors++; $display("FAIL basic_free_after_done got=%b exp=10", bus.in_ep_data_free);
    end
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pkt_start !== 1'b1 || bus.tx_pid !== 4'b0011) begin
      errors++; $display("FAIL basic_pid got start=%b pid=%b exp start=1 pid=0011", bus.tx_pkt_start, bus.tx_pid);
    end
    tick();
    checks++;
    if (bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL basic_start_one_cycle got=%b exp=0", bus.tx_pkt_start);
    end
    collect();
    checks++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      errors++; $display("FAIL basic_payload got size=%0d exp size=3 bytes 11 22 33", got.size());
    end
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    checks++;
    if (bus.in_ep_acked !== 2'b01 || bus.in_ep_data_free !== 2'b11) begin
      errors++; $display("FAIL basic_ack got acked=%b free=%b exp acked=01 free=11", bus.in_ep_acked, bus.in_ep_data_free);
    end
    tick();
    checks++;
    if (bus.in_ep_acked !== 2'b00) begin
      errors++; $display("FAIL basic_ack_pulse got=%b exp=00", bus.in_ep_acked);
    end
    put_byte(0, 8'h44); commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b1011) begin
      errors++; $display("FAIL basic_data1 got=%b exp=1011", bus.tx_pid);
    end
    tick(); collect();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h44) begin
      errors++; $display("FAIL basic_data1_payload got size=%0d exp size=1 byte 44", got.size());
    end
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    tick();
  endtask

  task automatic test_nak();
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pkt_start !== 1'b1 || bus.tx_pid !== 4'b1010) begin
      errors++; $display("FAIL nak_pid got start=%b pid=%b exp start=1 pid=1010", bus.tx_pkt_start, bus.tx_pid);
    end
    tick();
    checks++;
    if (bus.tx_data_avail !== 1'b0) begin
      errors++; $display("FAIL nak_no_payload got avail=%b exp=0", bus.tx_data_avail);
    end
    token(4'b1001, DEV ^ 7'h01, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL wrong_addr_ignored got start=%b exp=0", bus.tx_pkt_start);
    end
    token(4'b1001, DEV, 4'd2, 1'b1);
    checks++;
    if (bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL bad_endp_ignored got start=%b exp=0", bus.tx_pkt_start);
    end
    token(4'b1001, DEV, 4'd0, 1'b0);
    checks++;
    if (bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL invalid_pkt_ignored got start=%b exp=0", bus.tx_pkt_start);
    end
  endtask

  task automatic test_timeout();
    put_byte(0, 8'hAA); put_byte(0, 8'hBB); commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    tick();
    // A second IN while the transfer is active must not start a new packet.
    token(4'b1001, DEV, 4'd1, 1'b1);
    checks++;
    if (bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL busy_in_ignored got start=%b exp=0", bus.tx_pkt_start);
    end
    collect();
    strobes(20);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b0011) begin
      errors++; $display("FAIL retry_pid got=%b exp=0011", bus.tx_pid);
    end
    tick(); collect();
    checks++;
    if (got.size() != 2 || got[0] !== 8'hAA || got[1] !== 8'hBB) begin
      errors++; $display("FAIL retry_payload got size=%0d exp size=2 bytes AA BB", got.size());
    end
    // 19 strobes is still inside the ACK window.
    strobes(19);
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    checks++;
    if (bus.in_ep_acked !== 2'b01) begin
      errors++; $display("FAIL ack_after_19_strobes got=%b exp=01", bus.in_ep_acked);
    end
    tick();
  endtask

  task automatic test_stall();
    bus.in_ep_stall[0] = 1'b1;
    tick();
    checks++;
    if (bus.in_ep_data_free !== 2'b10) begin
      errors++; $display("FAIL stall_free got=%b exp=10", bus.in_ep_data_free);
    end
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b1110) begin
      errors++; $display("FAIL stall_pid got=%b exp=1110", bus.tx_pid);
    end
    tick();
    bus.in_ep_stall = '0;
    tick();
    token(4'b1101, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.in_ep_data_free !== 2'b11) begin
      errors++; $display("FAIL setup_clears_stall got=%b exp=11", bus.in_ep_data_free);
    end
    put_byte(0, 8'h55); commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b1011) begin
      errors++; $display("FAIL setup_data1 got=%b exp=1011", bus.tx_pid);
    end
    tick(); collect();
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 40; i++) put_byte(0, 8'(i));
    commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b0011) begin
      errors++; $display("FAIL overflow_pid got=%b exp=0011", bus.tx_pid);
    end
    tick(); collect();
    checks++;
    if (got.size() != 32) begin
      errors++; $display("FAIL overflow_len got=%0d exp=32", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(i)) begin
        errors++; $display("FAIL overflow_byte%0d got=%h exp=%h", i, got[i], 8'(i));
      end
    end
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    tick();
    // Endpoint clear restores DATA0 and an empty buffer.
    bus.reset_ep[0] = 1'b1; tick(); bus.reset_ep = '0;
    commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b0011) begin
      errors++; $display("FAIL zlp_pid got=%b exp=0011", bus.tx_pid);
    end
    tick();
    checks++;
    if (bus.tx_data_avail !== 1'b0) begin
      errors++; $display("FAIL zlp_avail got=%b exp=0", bus.tx_data_avail);
    end
    collect();
    token(4'b0010, 7'h00, 4'd0, 1'b1);
    checks++;
    if (bus.in_ep_acked !== 2'b01) begin
      errors++; $display("FAIL zlp_ack got=%b exp=01", bus.in_ep_acked);
    end
    tick();
  endtask

  task automatic test_ep1();
    put_byte(1, 8'h66); commit(1);
    checks++;
    if (bus.in_ep_data_free !== 2'b01) begin
      errors++; $display("FAIL ep1_free got=%b exp=01", bus.in_ep_data_free);
    end
    token(4'b1001, DEV, 4'd1, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b0011) begin
      errors++; $display("FAIL ep1_pid got=%b exp=0011", bus.tx_pid);
    end
    tick(); collect();
    checks++;
    if (got.size() != 1 || got[0] !== 8'h66) begin
      errors++; $display("FAIL ep1_payload got size=%0d exp size=1 byte 66", got.size());
    end
    token(4'b0010, 7'h00, 4'd1, 1'b1);
    checks++;
    if (bus.in_ep_acked !== 2'b10) begin
      errors++; $display("FAIL ep1_ack got=%b exp=10", bus.in_ep_acked);
    end
    tick();
  endtask

  task automatic test_reset_midtransfer();
    put_byte(0, 8'h77); commit(0);
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b1011) begin
      errors++; $display("FAIL mid_pid got=%b exp=1011", bus.tx_pid);
    end
    tick();
    checks++;
    if (bus.tx_data_avail !== 1'b1 || bus.tx_data !== 8'h77) begin
      errors++; $display("FAIL mid_data got avail=%b data=%h exp avail=1 data=77", bus.tx_data_avail, bus.tx_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_pkt_start, bus.tx_data_avail, bus.tx_data, bus.tx_pid} !== 14'h0) begin
      errors++; $display("FAIL mid_reset_outputs got=%h exp=0",
                         {bus.tx_pkt_start, bus.tx_data_avail, bus.tx_data, bus.tx_pid});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ep_data_free !== 2'b11 || bus.tx_pkt_start !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset got free=%b start=%b exp free=11 start=0",
                         bus.in_ep_data_free, bus.tx_pkt_start);
    end
    token(4'b1001, DEV, 4'd0, 1'b1);
    checks++;
    if (bus.tx_pid !== 4'b1010) begin
      errors++; $display("FAIL mid_nak got=%b exp=1010", bus.tx_pid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nak();
    test_timeout();
    test_stall();
    test_overflow();
    test_ep1();
    test_reset_midtransfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_fs_in_pe.md
USB_FS_IN_PE -- requirements
Module: usb_fs_in_pe

Interface
REQ-001 SHALL have parameter NUM_IN_EPS, default 1, number of IN endpoints (1..16).
REQ-002 SHALL have parameter MAX_IN_PACKET_SIZE, default 32, bytes per endpoint buffer.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port reset_ep  input  NUM_IN_EPS  synchronous per-endpoint clear.
REQ-006 SHALL have port dev_addr  input  7  device address.
REQ-007 SHALL have port bit_strobe  input  1  one-cycle pulse per USB bit time.
REQ-008 SHALL have port in_ep_data_free  output  NUM_IN_EPS  endpoint buffer accepting bytes.
REQ-009 SHALL have port in_ep_data_put  input  NUM_IN_EPS  write strobe, at most one bit set.
REQ-010 SHALL have port in_ep_data  input  8  byte written on put.
REQ-011 SHALL have port in_ep_data_done  input  NUM_IN_EPS  commit buffered packet for sending.
REQ-012 SHALL have port in_ep_stall  input  NUM_IN_EPS  force endpoint to STALL.
REQ-013 SHALL have port in_ep_acked  output  NUM_IN_EPS  one-cycle pulse when host ACKs that endpoint's packet.
REQ-014 SHALL have port rx_pkt_end  input  1  strobe at end of received packet.
REQ-015 SHALL have port rx_pkt_valid  input  1  received packet CRC/PID valid, qualified by rx_pkt_end.
REQ-016 SHALL have port rx_pid  input  4  received PID.
REQ-017 SHALL have port rx_addr  input  7  received token address.
REQ-018 SHALL have port rx_endp  input  4  received token endpoint.
REQ-019 SHALL have port tx_pkt_start  output  1  one-cycle strobe to start a tx packet.
REQ-020 SHALL have port tx_pkt_end  input  1  strobe when tx packet is fully sent.
REQ-021 SHALL have port tx_pid  output  4  PID of packet being started.
REQ-022 SHALL have port tx_data_avail  output  1  payload byte pending.
REQ-023 SHALL have port tx_data_get  input  1  tx consumes tx_data this cycle.
REQ-024 SHALL have port tx_data  output  8  current payload byte, valid while tx_data_avail.

Function
REQ-025 SHALL define an IN token as rx_pkt_end & rx_pkt_valid & rx_pid==4'b1001 & rx_addr==dev_addr & rx_endp<NUM_IN_EPS; a SETUP token uses rx_pid==4'b1101 with the same qualifiers.
REQ-026 SHALL keep per-endpoint state FILLING/READY/STALL; in_ep_data_free = (state==FILLING).
REQ-027 SHALL, in FILLING, write in_ep_data at put_addr and increment put_addr on put; puts at put_addr==MAX_IN_PACKET_SIZE are dropped (saturate); puts in READY/STALL are ignored.
REQ-028 SHALL, on done in FILLING, move to READY; a same-cycle put is included; done with put_addr==0 commits a zero-length packet.
REQ-029 SHALL have transfer FSM IDLE->RCVD_IN on IN token (latch rx_endp as current_endp); RCVD_IN lasts one cycle and asserts tx_pkt_start.
REQ-030 SHALL, in RCVD_IN, choose tx_pid: STALL 4'b1110 if endpoint STALL; else DATA0 4'b0011/DATA1 4'b1011 per toggle if READY (next state SEND_DATA); else NAK 4'b1010 (next state IDLE).
REQ-031 SHALL, in SEND_DATA, assert tx_data_avail while get_addr<put_addr, present buffer[get_addr] combinationally on tx_data, and advance get_addr on tx_data_get; on tx_pkt_end go to WAIT_ACK and clear the timeout counter.
REQ-032 SHALL, in WAIT_ACK, on valid ACK (rx_pid 4'b0010) flip the toggle, clear put_addr, return the endpoint to FILLING, pulse in_ep_acked, and go IDLE.
REQ-033 SHALL, in WAIT_ACK, on any other rx_pkt_end or after 20 bit_strobe pulses, go IDLE keeping the data and toggle; a retry resends from get_addr=0.
REQ-034 SHALL reset get_addr to 0 on entry to RCVD_IN.
REQ-035 SHALL make in_ep_stall force STALL (priority over all transitions); a SETUP token to that endpoint returns it to FILLING with put_addr=0 and sets its toggle to 1.
REQ-036 SHALL ignore IN tokens outside IDLE.

Reset
REQ-037 SHALL, while reset==0, force FSM IDLE, endpoints FILLING, put/get_addr 0, toggles 0, tx_pkt_start 0, tx_pid 0, tx_data_avail 0, tx_data 0, in_ep_acked 0; reset mid-transfer aborts with no further tx strobes.
REQ-038 SHALL, on reset_ep[i], clear endpoint i to FILLING, put_addr 0, toggle 0 next cycle.

Verification
REQ-039 SHALL cover: put 3 bytes 0x11,0x22,0x33 + done, IN token -> tx_pid 0011, bytes in order, ACK -> in_ep_acked pulse, free=1, next send DATA1.
REQ-040 SHALL cover: IN token with endpoint FILLING -> tx_pid 1010, no payload.
REQ-041 SHALL cover: after data sent, no ACK for 20 bit strobes -> retry resends same bytes with DATA0.
REQ-042 SHALL cover: in_ep_stall=1, IN token -> tx_pid 1110; SETUP token -> free=1, next data DATA1.
REQ-043 SHALL cover: 40 puts then done -> exactly 32 bytes sent; done with no puts -> DATA0 with zero payload.
